// File: rtl/note_pkg.sv
// Shared definitions for the note player: command codes, FSM states, note width.
package note_pkg;

    localparam int unsigned NOTE_W = 3;

    // Command encodings on the op input
    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_PLAY  = 2'b01;
    localparam logic [1:0] OP_PAUSE = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StPlay  = 2'b01,
        StPause = 2'b10
    } state_e;

endpackage

// File: rtl/note_player_buf.sv
// Note storage: register array with one synchronous write port and one
// combinational read port. Contents are not reset; count tracks validity.
module note_player_buf #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned WIDTH = 3,
    localparam int unsigned AddrW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AddrW-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AddrW-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/note_player.sv
// Note player: loads notes into a buffer, then plays them back holding each
// for tempo+1 cycles, with pause/resume and clear. All outputs are registered.
module note_player
    import note_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    localparam int unsigned IdxW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NOTE_W-1:0] note_in,
    input  logic [1:0]        op,
    input  logic [3:0]        tempo,
    output logic [NOTE_W-1:0] note_out,
    output logic              playing,
    output logic              done,
    output logic [IdxW:0]     count,
    output logic              full
);

    localparam logic [IdxW:0] CntMax = (IdxW + 1)'(DEPTH);

    state_e            state_q, state_d;
    logic [IdxW:0]     count_q, count_d;
    logic [IdxW-1:0]   index_q, index_d;
    logic [3:0]        hold_q, hold_d;
    logic [3:0]        tempo_q, tempo_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic              done_q, done_d;
    logic              playing_q, full_q;

    logic              buf_we;
    logic [IdxW-1:0]   rd_addr;
    logic [NOTE_W-1:0] rd_data;
    logic              step;
    logic              last;

    note_player_buf #(
        .DEPTH (DEPTH),
        .WIDTH (NOTE_W)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (count_q[IdxW-1:0]),
        .wdata (note_in),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign last = ({1'b0, index_q} == count_q - 1'b1);

    // Next-state: command decode, hold/index stepping, clear override
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        index_d = index_q;
        hold_d  = hold_q;
        tempo_d = tempo_q;
        note_d  = note_q;
        done_d  = 1'b0;
        buf_we  = 1'b0;
        step    = 1'b0;
        // Idle reads slot 0 for play start; otherwise prefetch the next note
        rd_addr = (state_q == StIdle) ? '0 : index_q + 1'b1;

        unique case (state_q)
            StIdle: begin
                case (op)
                    OP_LOAD: begin
                        if (!full_q) begin
                            buf_we  = 1'b1;
                            count_d = count_q + 1'b1;
                        end
                    end
                    OP_PLAY: begin
                        if (count_q != '0) begin
                            tempo_d = tempo;
                            index_d = '0;
                            hold_d  = '0;
                            note_d  = rd_data;
                            state_d = StPlay;
                        end
                    end
                    default: ;
                endcase
            end
            StPlay: begin
                if (op == OP_PAUSE) begin
                    state_d = StPause;
                end else if (op != OP_CLEAR) begin
                    step = 1'b1;
                end
            end
            StPause: begin
                // The resume edge counts as a playing cycle
                if (op == OP_PLAY) begin
                    state_d = StPlay;
                    step    = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (step) begin
            if (hold_q == tempo_q) begin
                hold_d = '0;
                if (last) begin
                    state_d = StIdle;
                    index_d = '0;
                    note_d  = '0;
                    done_d  = 1'b1;
                end else begin
                    index_d = index_q + 1'b1;
                    note_d  = rd_data;
                end
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end

        // Clear wins over everything, including a coincident final expiry
        if (op == OP_CLEAR) begin
            state_d = StIdle;
            count_d = '0;
            index_d = '0;
            hold_d  = '0;
            note_d  = '0;
            done_d  = 1'b0;
            buf_we  = 1'b0;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            count_q   <= '0;
            index_q   <= '0;
            hold_q    <= '0;
            tempo_q   <= '0;
            note_q    <= '0;
            done_q    <= 1'b0;
            playing_q <= 1'b0;
            full_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            index_q   <= index_d;
            hold_q    <= hold_d;
            tempo_q   <= tempo_d;
            note_q    <= note_d;
            done_q    <= done_d;
            playing_q <= (state_d == StPlay);
            full_q    <= (count_d == CntMax);
        end
    end

    assign note_out = note_q;
    assign playing  = playing_q;
    assign done     = done_q;
    assign count    = count_q;
    assign full     = full_q;

endmodule

// File: tb/tb_note_player.sv
// Scoreboard bench for note_player: stimulus pushes the expected per-cycle
// {playing, done, note_out} into a queue, a negedge monitor pops and compares.
module tb_note_player;
    import note_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] note_in;
    logic [1:0] op;
    logic [3:0] tempo;
    logic [2:0] note_out;
    logic       playing;
    logic       done;
    logic [5:0] count;
    logic       full;

    int n_checks = 0;
    int n_errors = 0;

    logic [4:0] exp_q [$];     // {playing, done, note}
    logic [2:0] model_buf [$]; // notes the buffer should hold

    always #5 clk = ~clk;

    note_player #(
        .DEPTH (32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .note_in  (note_in),
        .op       (op),
        .tempo    (tempo),
        .note_out (note_out),
        .playing  (playing),
        .done     (done),
        .count    (count),
        .full     (full)
    );

    // Monitor: any cycle with playing or done must match the next expectation
    always @(negedge clk) begin
        if (!reset && (playing || done)) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_output: got play=%0b done=%0b note=%0d, required none",
                         playing, done, note_out);
            end else begin
                logic [4:0] e;
                e = exp_q.pop_front();
                if ({playing, done, note_out} != e) begin
                    n_errors++;
                    $display("FAIL playback_seq: got play=%0b done=%0b note=%0d, required play=%0b done=%0b note=%0d",
                             playing, done, note_out, e[4], e[3], e[2:0]);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic drive(input logic [1:0] o, input logic [2:0] n, input logic [3:0] t);
        op      = o;
        note_in = n;
        tempo   = t;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] n);
        if (model_buf.size() < 32) model_buf.push_back(n);
        drive(OP_LOAD, n, 4'd0);
    endtask

    task automatic clear();
        model_buf.delete();
        drive(OP_CLEAR, 3'd0, 4'd0);
    endtask

    // op=10 is a no-op in IDLE; op=00 is a no-op in PLAY
    task automatic idle(input int k);
        repeat (k) drive(OP_PAUSE, 3'd0, 4'd0);
    endtask

    task automatic run(input int k);
        repeat (k) drive(OP_LOAD, 3'd0, 4'd0);
    endtask

    task automatic expect_note(input logic [2:0] n, input int cycles);
        repeat (cycles) exp_q.push_back({1'b1, 1'b0, n});
    endtask

    task automatic expect_done();
        exp_q.push_back({1'b0, 1'b1, 3'd0});
    endtask

    // Full playback of the modelled buffer with no interruption
    task automatic play_all(input logic [3:0] t);
        int n;
        n = model_buf.size();
        foreach (model_buf[i]) expect_note(model_buf[i], int'(t) + 1);
        expect_done();
        drive(OP_PLAY, 3'd0, t);
        run(n * (int'(t) + 1));
        idle(2);
    endtask

    task automatic drain(input string name);
        idle(1);
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        reset   = 1'b1;
        op      = OP_PAUSE;
        note_in = '0;
        tempo   = '0;
        #12;
        check("reset_note_out", note_out, 0);
        check("reset_playing", playing, 0);
        check("reset_done", done, 0);
        check("reset_count", count, 0);
        check("reset_full", full, 0);
        @(negedge clk);
        reset = 1'b0;

        // Basic load and play: 5,5,3,3,7,7 then done
        load(3'd5);
        load(3'd3);
        load(3'd7);
        idle(1);
        check("load3_count", count, 3);
        check("load3_full", full, 0);
        play_all(4'd1);
        drain("play_t1_drained");
        check("after_done_count", count, 3);

        // Replay without reloading at a new tempo
        play_all(4'd0);
        drain("replay_t0_drained");

        // Play with an empty buffer is ignored
        clear();
        check("clear_count", count, 0);
        drive(OP_PLAY, 3'd0, 4'd2);
        check("empty_play_playing", playing, 0);
        check("empty_play_done", done, 0);
        idle(2);

        // Saturating load: 33 notes, the last one must not land anywhere
        load(3'd1);
        check("first_load_count", count, 1);
        check("first_load_full", full, 0);
        for (int i = 1; i < 32; i++) load(3'((i * 5 + 1) % 8));
        check("fill_count", count, 32);
        check("fill_full", full, 1);
        load(3'd6);
        check("overfill_count", count, 32);
        check("overfill_full", full, 1);
        idle(1);
        play_all(4'd0);
        drain("play32_drained");
        check("play32_count_kept", count, 32);

        // Pause/resume: 4 notes, tempo 3, op=10 held for edges 6..10
        clear();
        load(3'd2);
        load(3'd4);
        load(3'd6);
        load(3'd1);
        expect_note(3'd2, 4);
        expect_note(3'd4, 4);
        expect_note(3'd6, 4);
        expect_note(3'd1, 4);
        expect_done();
        drive(OP_PLAY, 3'd0, 4'd3);
        run(5);
        drive(OP_PAUSE, 3'd0, 4'd0);
        check("pause_playing", playing, 0);
        check("pause_note_held", note_out, 4);
        // A different tempo here must not be re-sampled on resume
        drive(OP_PAUSE, 3'd0, 4'd9);
        drive(OP_LOAD, 3'd7, 4'd9);
        drive(OP_PAUSE, 3'd0, 4'd9);
        drive(OP_PAUSE, 3'd0, 4'd9);
        check("pause_note_still", note_out, 4);
        check("pause_count_kept", count, 4);
        drive(OP_PLAY, 3'd0, 4'd0);
        run(9);
        check("pause_no_early_done", done, 0);
        run(1);
        check("pause_done_cycle21", done, 1);
        idle(2);
        drain("pause_drained");

        // Clear during playback
        expect_note(3'd2, 3);
        drive(OP_PLAY, 3'd0, 4'd2);
        run(2);
        clear();
        check("clear_play_count", count, 0);
        check("clear_play_note", note_out, 0);
        check("clear_play_playing", playing, 0);
        check("clear_play_done", done, 0);
        drive(OP_PLAY, 3'd0, 4'd2);
        check("clear_then_play_ignored", playing, 0);
        drain("clear_play_drained");

        // Clear coinciding with the final hold expiry suppresses done
        load(3'd5);
        expect_note(3'd5, 1);
        drive(OP_PLAY, 3'd0, 4'd0);
        clear();
        check("clear_beats_done", done, 0);
        check("clear_beats_done_count", count, 0);
        drain("clear_final_drained");

        // Asynchronous reset mid-hold
        load(3'd3);
        load(3'd6);
        expect_note(3'd3, 3);
        drive(OP_PLAY, 3'd0, 4'd15);
        run(3);
        reset = 1'b1;
        #1;
        check("async_rst_note", note_out, 0);
        check("async_rst_playing", playing, 0);
        check("async_rst_done", done, 0);
        check("async_rst_count", count, 0);
        check("async_rst_full", full, 0);
        model_buf.delete();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("async_rst_no_done", done, 0);
        load(3'd3);
        check("post_reset_first_load", count, 1);
        drain("async_rst_drained");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
